// File: rtl/sync_filter_edge.sv
// Per-bit level synchroniser with an optional stability filter
// and rise/fall pulse outputs for quasi-static async inputs.
module sync_filter_edge #(
   parameter int             N       = 8,
   parameter int             STAGES  = 2,
   parameter int             FILTER  = 0,
   parameter logic [N-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] data_in,
   output logic [N-1:0] data_out,
   output logic [N-1:0] rise_pulse,
   output logic [N-1:0] fall_pulse,
   output logic         any_change
);

   if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
      $error("sync_filter_edge: STAGES must be 2..4");
   end

   if (FILTER < 0 || FILTER > 255) begin : g_bad_filter
      $error("sync_filter_edge: FILTER must be 0..255");
   end

   logic [STAGES-1:0][N-1:0] chain;
   logic [N-1:0]             sync_q;
   logic [N-1:0]             prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chain <= {STAGES{RST_VAL}};
      end else begin
         chain <= {chain[STAGES-2:0], data_in};
      end
   end

   assign sync_q = chain[STAGES-1];

   if (FILTER == 0) begin : g_nofilt
      assign data_out = sync_q;
   end else begin : g_filt
      localparam int            CW   = $clog2(FILTER + 1);
      localparam logic [CW-1:0] LAST = CW'(FILTER - 1);

      logic [N-1:0] level;

      // One counter per channel; it only runs while the bit disagrees.
      for (genvar i = 0; i < N; i++) begin : g_bit
         logic [CW-1:0] cnt;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               level[i] <= RST_VAL[i];
               cnt      <= '0;
            end else if (sync_q[i] == level[i]) begin
               cnt      <= '0;
            end else if (cnt == LAST) begin
               level[i] <= sync_q[i];
               cnt      <= '0;
            end else begin
               cnt      <= cnt + 1'b1;
            end
         end
      end

      assign data_out = level;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev <= RST_VAL;
      end else begin
         prev <= data_out;
      end
   end

   assign rise_pulse = data_out & ~prev;
   assign fall_pulse = ~data_out & prev;
   assign any_change = |(rise_pulse | fall_pulse);

endmodule
